// File: rtl/ysyx_22040088_ifu_if.sv
// ysyx_22040088_ifu_if: fetch-unit bus bundle (imem request/response, decode handoff, commit feedback).
//   master: IFU side; drives imem_req_*, imem_resp_ready, inst_valid, inst, inst_pc.
//   slave : environment side (memory, decode, execute); drives the remaining signals.
interface ysyx_22040088_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        commit_valid;
  logic [63:0] commit_nextpc;
  modport master (
    output imem_req_valid, imem_req_addr, imem_resp_ready, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready,
           commit_valid, commit_nextpc
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, imem_resp_ready, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready,
           commit_valid, commit_nextpc
  );
endinterface

// File: rtl/ysyx_22040088_ifu.sv
// ysyx_22040088_ifu: single-outstanding instruction fetch unit (IDLE/REQ/WAIT/VALID/EXEC/HALT).
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   bus (master)   : imem request/response, instruction handoff to decode, commit nextpc from execute
//   fetch_err      : sticky fault (access error or misaligned nextpc); fetch halted until reset
//   perf_fetch_cnt : accepted responses (only with YSYX_22040088_IFU_PERF_EN, else tied 0)
//   perf_stall_cnt : REQ/WAIT cycles without handshake (only with YSYX_22040088_IFU_PERF_EN, else tied 0)
module ysyx_22040088_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          STALL_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_22040088_ifu_if.master bus,
  output logic               fetch_err,
  output logic [STALL_W-1:0] perf_fetch_cnt,
  output logic [STALL_W-1:0] perf_stall_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, EXEC, HALT} state_t;
  state_t      state, state_nx;
  logic [63:0] pc;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = REQ;
      REQ:     state_nx = bus.imem_req_ready ? WAIT : REQ;
      WAIT:    state_nx = !bus.imem_resp_valid ? WAIT : bus.imem_resp_err ? HALT : VALID;
      VALID:   state_nx = bus.inst_ready ? EXEC : VALID;
      // a misaligned target faults here so no request is ever issued for it
      EXEC:    state_nx = !bus.commit_valid ? EXEC : (bus.commit_nextpc[1:0] != 2'b00) ? HALT : REQ;
      default: state_nx = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == WAIT && bus.imem_resp_valid && !bus.imem_resp_err) begin
        inst_q    <= bus.imem_resp_data;
        inst_pc_q <= pc;
      end
      if (state == EXEC && bus.commit_valid) pc <= bus.commit_nextpc;
      if (state_nx == HALT) fetch_err <= 1'b1;
    end
  end
  // handshake outputs decode from state only: mutually exclusive, no input-to-output path
  assign bus.imem_req_valid  = state == REQ;
  assign bus.imem_req_addr   = state == REQ ? pc : '0;
  assign bus.imem_resp_ready = state == WAIT;
  assign bus.inst_valid      = state == VALID;
  assign bus.inst            = inst_q;
  assign bus.inst_pc         = inst_pc_q;
`ifdef YSYX_22040088_IFU_PERF_EN
  logic [STALL_W-1:0] fetch_cnt, stall_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == WAIT && bus.imem_resp_valid) fetch_cnt <= fetch_cnt + STALL_W'(1);
      if ((state == REQ && !bus.imem_req_ready) || (state == WAIT && !bus.imem_resp_valid))
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// tb_ysyx_22040088_ifu: table-driven and randomized transaction checks of the fetch unit.
module tb_ysyx_22040088_ifu;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
`ifdef YSYX_22040088_IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          dreq;
    int          dresp;
    int          dacc;
    int          dcm;
    logic        ghost;
    logic [63:0] nextpc;
    logic [63:0] exp_addr;
    logic        exp_halt;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_err;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  int          n_chk = 0, n_fail = 0;
  int          exp_fetch = 0, exp_stall = 0;
  logic [63:0] model_pc;
  vec_t        tbl[7];
  ysyx_22040088_ifu_if bus ();
  ysyx_22040088_ifu #(.RESET_PC(RESET_PC), .STALL_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fetch_err(fetch_err),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic idle_inputs;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.commit_valid    = 1'b0;
    bus.commit_nextpc   = 64'h0;
  endtask
  task automatic chk_perf;
    chk("perf_fetch", 64'(perf_fetch_cnt), PERF ? 64'(exp_fetch) : 64'h0);
    chk("perf_stall", 64'(perf_stall_cnt), PERF ? 64'(exp_stall) : 64'h0);
  endtask
  // asserts reset mid-cycle and checks that everything clears before any clock edge
  task automatic do_reset;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_resp_ready", bus.imem_resp_ready, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_fetch_err", fetch_err, 0);
    exp_fetch = 0;
    exp_stall = 0;
    chk_perf();
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b1;
    model_pc = RESET_PC;
  endtask
  task automatic halt_check;
    repeat (6) begin
      bus.commit_valid   = 1'b1;
      bus.commit_nextpc  = RESET_PC;
      bus.imem_req_ready = 1'b1;
      cyc();
      chk("halt_quiet", {61'h0, bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid}, 0);
    end
    idle_inputs();
  endtask
  // one full fetch: request, response, decode handoff, commit
  task automatic txn(input vec_t v, input logic [63:0] exp_addr, input logic exp_halt);
    int t;
    logic [63:0] g;
    t = 0;
    while (!bus.imem_req_valid && t < 20) begin
      cyc();
      t++;
    end
    chk("req_valid", bus.imem_req_valid, 1);
    if (!bus.imem_req_valid) return;
    chk("req_addr", bus.imem_req_addr, exp_addr);
    repeat (v.dreq) begin
      cyc();
      chk("req_hold_valid", bus.imem_req_valid, 1);
      chk("req_hold_addr", bus.imem_req_addr, exp_addr);
    end
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    exp_stall += v.dreq;
    chk("resp_ready", bus.imem_resp_ready, 1);
    chk("req_drop", bus.imem_req_valid, 0);
    repeat (v.dresp) cyc();
    exp_stall += v.dresp;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = v.data;
    bus.imem_resp_err   = v.err;
    cyc();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = 1'b0;
    bus.imem_resp_data  = $urandom;
    exp_fetch++;
    if (v.err) begin
      chk("fetch_err", fetch_err, exp_halt);
      halt_check();
      chk_perf();
      return;
    end
    chk("inst_valid", bus.inst_valid, 1);
    chk("inst", bus.inst, v.data);
    chk("inst_pc", bus.inst_pc, exp_addr);
    repeat (v.dacc) begin
      g = {$urandom, $urandom};
      g[1:0] = 2'b00;
      bus.commit_valid  = v.ghost;
      bus.commit_nextpc = g;
      cyc();
      bus.commit_valid = 1'b0;
      chk("inst_hold_valid", bus.inst_valid, 1);
      chk("inst_hold", bus.inst, v.data);
      chk("inst_pc_hold", bus.inst_pc, exp_addr);
      chk("no_req_in_valid", bus.imem_req_valid, 0);
    end
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    chk("inst_taken", bus.inst_valid, 0);
    repeat (v.dcm) begin
      cyc();
      chk("no_req_in_exec", bus.imem_req_valid, 0);
    end
    bus.commit_valid  = 1'b1;
    bus.commit_nextpc = v.nextpc;
    cyc();
    bus.commit_valid = 1'b0;
    chk_perf();
    chk("fetch_err", fetch_err, exp_halt);
    if (exp_halt) halt_check();
    else chk("next_addr", bus.imem_req_addr, v.nextpc);
  endtask
  initial begin
    vec_t v;
    logic mis;
    idle_inputs();
    //          data          err dreq dresp dacc dcm ghost nextpc                 exp_addr               halt
    tbl[0] = '{32'h00000413, 0,  0,   0,    0,   0,  0,    64'h0000_0000_8000_0010, 64'h0000_0000_8000_0000, 0};
    tbl[1] = '{32'h00100093, 0,  5,   3,    0,   1,  0,    64'h0000_0000_8000_0014, 64'h0000_0000_8000_0010, 0};
    tbl[2] = '{32'h12345678, 0,  0,   1,    4,   2,  1,    64'h0000_0000_8000_0100, 64'h0000_0000_8000_0014, 0};
    tbl[3] = '{32'hdeadbeef, 0,  2,   0,    1,   0,  1,    64'h0000_0000_8000_0002, 64'h0000_0000_8000_0100, 1};
    tbl[4] = '{32'hcafef00d, 1,  1,   2,    0,   0,  0,    64'h0000_0000_8000_0040, 64'h0000_0000_8000_0000, 1};
    tbl[5] = '{32'h0000006f, 0,  0,   0,    2,   3,  1,    64'h0000_0000_0000_1000, 64'h0000_0000_8000_0000, 0};
    tbl[6] = '{32'h00008067, 0,  3,   3,    0,   0,  0,    64'h0000_0000_8000_0003, 64'h0000_0000_0000_1000, 1};
    do_reset();
    // zero-wait memory: request on cycle 1, instruction to decode on cycle 3
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h00000413;
    chk("c0_idle", {61'h0, bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid}, 0);
    cyc();
    chk("c1_req_valid", bus.imem_req_valid, 1);
    chk("c1_req_addr", bus.imem_req_addr, 64'h8000_0000);
    cyc();
    chk("c2_resp_ready", bus.imem_resp_ready, 1);
    cyc();
    chk("c3_inst_valid", bus.inst_valid, 1);
    chk("c3_inst", bus.inst, 32'h00000413);
    chk("c3_inst_pc", bus.inst_pc, 64'h8000_0000);
    idle_inputs();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      txn(tbl[i], tbl[i].exp_addr, tbl[i].exp_halt);
      if (tbl[i].exp_halt) do_reset();
    end
    // reset while a response is outstanding, then a clean restart from RESET_PC
    cyc();
    chk("w_req", bus.imem_req_valid, 1);
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    chk("w_in_wait", bus.imem_resp_ready, 1);
    do_reset();
    v = '{32'h00a00513, 0, 0, 0, 0, 0, 0, 64'h0000_0000_8000_0008, 64'h0, 0};
    txn(v, RESET_PC, 1'b0);
    model_pc = v.nextpc;
    // randomized transactions against the address/perf model
    for (int i = 0; i < 60; i++) begin
      v.data   = $urandom;
      v.err    = $urandom_range(0, 14) == 0;
      v.dreq   = $urandom_range(0, 3);
      v.dresp  = $urandom_range(0, 3);
      v.dacc   = $urandom_range(0, 3);
      v.dcm    = $urandom_range(0, 3);
      v.ghost  = $urandom_range(0, 1) == 1;
      v.nextpc = {$urandom, $urandom};
      mis = $urandom_range(0, 9) == 0;
      v.nextpc[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      v.exp_addr = model_pc;
      v.exp_halt = v.err || mis;
      txn(v, v.exp_addr, v.exp_halt);
      if (v.exp_halt) do_reset();
      else model_pc = v.nextpc;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040088_ifu.md
YSYX_22040088_IFU -- requirements
Module: ysyx_22040088_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter STALL_W, default 32, meaning the width of the perf counters.
REQ-003 SHALL have port clk, in, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, in, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port imem_req_valid, out, 1, fetch request valid.
REQ-006 SHALL have port imem_req_ready, in, 1, memory accepts request.
REQ-007 SHALL have port imem_req_addr, out, 64, fetch address (current pc).
REQ-008 SHALL have port imem_resp_valid, in, 1, response valid.
REQ-009 SHALL have port imem_resp_ready, out, 1, IFU accepts response.
REQ-010 SHALL have port imem_resp_data, in, 32, instruction word.
REQ-011 SHALL have port imem_resp_err, in, 1, access fault qualifying resp_valid.
REQ-012 SHALL have port inst_valid, out, 1, instruction available to decode.
REQ-013 SHALL have port inst_ready, in, 1, decode accepts instruction.
REQ-014 SHALL have port inst, out, 32, held instruction word.
REQ-015 SHALL have port inst_pc, out, 64, pc of held instruction (feeds execute pc input).
REQ-016 SHALL have port commit_valid, in, 1, execute has produced nextpc for the issued instruction.
REQ-017 SHALL have port commit_nextpc, in, 64, next pc from execute.
REQ-018 SHALL have port fetch_err, out, 1, sticky fault flag; fetch halted.
REQ-019 SHALL have ports perf_fetch_cnt and perf_stall_cnt, out, STALL_W each, perf counters.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, VALID, EXEC, HALT.
REQ-021 IDLE SHALL drive all handshake outputs 0 and go to REQ on the next edge.
REQ-022 REQ SHALL assert imem_req_valid with imem_req_addr=pc, holding both stable until imem_req_ready; the handshake edge moves to WAIT.
REQ-023 WAIT SHALL assert imem_resp_ready; on imem_resp_valid with err=0, capture inst<=imem_resp_data, inst_pc<=pc, and go to VALID; with err=1, set fetch_err and go to HALT.
REQ-024 VALID SHALL assert inst_valid with inst/inst_pc stable until inst_ready; the handshake edge moves to EXEC.
REQ-025 EXEC SHALL wait for commit_valid, then load pc<=commit_nextpc and go to REQ; minimum commit-to-next-request latency is 1 cycle.
REQ-026 commit_valid outside EXEC SHALL be ignored.
REQ-027 A commit_nextpc with bits[1:0]!=0 SHALL set fetch_err and go to HALT without issuing a request.
REQ-028 HALT SHALL be terminal until reset, with every handshake output 0.
REQ-029 imem_req_valid, imem_resp_ready and inst_valid SHALL be mutually exclusive and driven from state only (no combinational in->out path).
REQ-030 The pc register SHALL hold its value in all states except on the EXEC commit edge.

Reset
REQ-031 Reset assertion SHALL immediately force state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, fetch_err=0, counters=0, and all handshake outputs=0, regardless of the transaction in progress.
REQ-032 After reset, any response still pending in memory is the memory's responsibility to drop; the IFU SHALL NOT issue a new request until the first cycle after IDLE.

Configuration
REQ-033 With macro YSYX_22040088_IFU_PERF_EN defined: perf_fetch_cnt SHALL increment on each accepted response; perf_stall_cnt SHALL increment each cycle in REQ or WAIT without a handshake; both wrap modulo 2^STALL_W.
REQ-034 Without YSYX_22040088_IFU_PERF_EN: both ports SHALL be present and tied to 0, with no counter flops.

Verification
REQ-035 Reset release, memory with zero-wait ready/resp returning 32'h00000413 -> req addr 64'h80000000 on cycle 1, inst_valid with inst=32'h00000413 and inst_pc=64'h80000000 on cycle 3.
REQ-036 Commit with commit_nextpc=64'h80000010 in EXEC -> next imem_req_addr=64'h80000010; commit pulse in VALID -> ignored, pc unchanged.
REQ-037 req_ready held low 5 cycles, then resp delayed 3 -> addr stable throughout; perf_stall_cnt=8 with PERF_EN, 0 without.
REQ-038 resp_err=1 on resp -> fetch_err=1, no further imem_req_valid until reset; commit_nextpc=64'h80000002 -> fetch_err=1, no request.
REQ-039 rst low during WAIT -> outputs 0 asynchronously; after release, first request addr=RESET_PC.
REQ-040 inst_ready held low 4 cycles in VALID -> inst/inst_pc stable, no imem request issued.
